lsu_bus_master: RTL and testbench

// MEM-stage load/store initiator: accepts one access from the pipeline, checks alignment and address map,

---
 rtl/lsu_bus_master.sv | 234 +++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_master
// Purpose  : MEM-stage load/store initiator. Accepts one access, checks
//            alignment and the address map, runs a req/ack bus cycle toward
//            data memory or the timer bridge, and returns extended load data
//            or an AdEL/AdES exception as a one-cycle response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset (async active-low)
//   Pipeline : req_valid/req_ready, req_we, req_size, req_sign, req_addr,
//              req_wdata, req_ovf, flush
//   Response : resp_valid, resp_rdata, resp_exc, resp_exccode, resp_badvaddr,
//              busy
//   Bus      : bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_rdata,
//              bus_ack
// ============================================================================
module lsu_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_ovf,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] resp_badvaddr,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int         CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0] c_ADEL  = 5'd4;
  localparam logic [4:0] c_ADES  = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]   r_addr;
  logic          r_we;
  logic          r_half;
  logic          r_byte;
  logic          r_sign;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_exc;
  logic [4:0]    r_exccode;
  logic [31:0]   r_badvaddr;
  logic          r_kill;

  logic          w_accept;
  logic          w_half;
  logic          w_byte;
  logic          w_word;
  logic          w_in_dm;
  logic          w_in_tmr;
  logic          w_fault;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load;
  logic          w_timeout;
  logic          w_resp_valid;

  // --------------------------------------------------------------------------
  // Request decode (evaluated on the raw request at the accept edge)
  // --------------------------------------------------------------------------
  assign w_accept = req_valid & req_ready;
  assign w_half   = (req_size == 2'd1);
  assign w_byte   = (req_size == 2'd2);
  assign w_word   = ~w_half & ~w_byte;   // size 3 behaves as a word

  // Data memory 0x0000_0000-0x0000_2FFF.
  assign w_in_dm  = (req_addr[31:14] == 18'd0) && (req_addr[13:12] != 2'b11);
  // Two timer blocks at 0x7F00 and 0x7F10, three registers each; offset 0xC
  // of each 16-byte block is a hole.
  assign w_in_tmr = (req_addr[31:5] == 27'h3F8) && (req_addr[3:2] != 2'b11);

  always_comb begin
    w_fault = 1'b0;
    if (req_ovf)                                  w_fault = 1'b1;
    if (w_word && (req_addr[1:0] != 2'b00))       w_fault = 1'b1;
    if (w_half && req_addr[0])                    w_fault = 1'b1;
    if (!(w_in_dm || w_in_tmr))                   w_fault = 1'b1;
    // Timer registers are word-only, and the count register is read-only.
    if (w_in_tmr && !w_word)                      w_fault = 1'b1;
    if (w_in_tmr && req_we && (req_addr[3:2] == 2'b10)) w_fault = 1'b1;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = req_wdata;
    if (w_half) begin
      w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{req_wdata[15:0]}};
    end else if (w_byte) begin
      w_be    = 4'b0001 << req_addr[1:0];
      w_wdata = {4{req_wdata[7:0]}};
    end
  end

  // Lane select and extension of the returned word, using the latched request.
  always_comb begin
    logic [15:0] v_h;
    logic [7:0]  v_b;
    v_h    = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    v_b    = 8'h00;
    case (r_addr[1:0])
      2'd0:    v_b = bus_rdata[7:0];
      2'd1:    v_b = bus_rdata[15:8];
      2'd2:    v_b = bus_rdata[23:16];
      default: v_b = bus_rdata[31:24];
    endcase
    w_load = bus_rdata;
    if (r_half)      w_load = {{16{r_sign & v_h[15]}}, v_h};
    else if (r_byte) w_load = {{24{r_sign & v_b[7]}}, v_b};
  end

  assign w_timeout = (r_state == ST_BUS) && !bus_ack && (r_cnt == c_CNT_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_fault ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= 32'd0;
      r_we       <= 1'b0;
      r_half     <= 1'b0;
      r_byte     <= 1'b0;
      r_sign     <= 1'b0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_cnt      <= '0;
      r_rdata    <= 32'd0;
      r_exc      <= 1'b0;
      r_exccode  <= 5'd0;
      r_badvaddr <= 32'd0;
    end else if (w_accept) begin
      r_addr     <= req_addr;
      r_we       <= req_we;
      r_half     <= w_half;
      r_byte     <= w_byte;
      r_sign     <= req_sign;
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_cnt      <= '0;
      r_rdata    <= 32'd0;
      r_exc      <= w_fault;
      r_exccode  <= w_fault ? (req_we ? c_ADES : c_ADEL) : 5'd0;
      r_badvaddr <= w_fault ? req_addr : 32'd0;
    end else if (r_state == ST_BUS) begin
      if (bus_ack) begin
        r_rdata <= r_we ? 32'd0 : w_load;
      end else if (w_timeout) begin
        r_rdata    <= 32'd0;
        r_exc      <= 1'b1;
        r_exccode  <= r_we ? c_ADES : c_ADEL;
        r_badvaddr <= r_addr;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A flush during a transfer lets the bus cycle finish but hides the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              r_kill <= 1'b0;
    else if (r_state == ST_RESP)             r_kill <= 1'b0;
    else if (flush && (r_state == ST_BUS))   r_kill <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready     = (r_state == ST_IDLE) && !flush;
  assign busy          = (r_state != ST_IDLE);
  assign bus_req       = (r_state == ST_BUS);
  assign bus_we        = bus_req & r_we;
  assign bus_be        = bus_req ? r_be : 4'd0;
  assign bus_addr      = {r_addr[31:2], 2'b00};
  assign bus_wdata     = r_wdata;

  // A flush landing in the response cycle itself also suppresses it.
  assign w_resp_valid  = (r_state == ST_RESP) && !r_kill && !flush;
  assign resp_valid    = w_resp_valid;
  assign resp_rdata    = w_resp_valid ? r_rdata    : 32'd0;
  assign resp_exc      = w_resp_valid & r_exc;
  assign resp_exccode  = w_resp_valid ? r_exccode  : 5'd0;
  assign resp_badvaddr = w_resp_valid ? r_badvaddr : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_master
// Purpose  : Directed self-checking bench for lsu_bus_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ovf;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exccode;
  logic [31:0] resp_badvaddr;
  logic        busy;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;
  int nreq;

  lsu_bus_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ovf(req_ovf), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exccode(resp_exccode), .resp_badvaddr(resp_badvaddr), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single accept edge; returns one cycle after it.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic ovf);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata; req_ovf = ovf;
    cyc();
    req_valid = 1'b0; req_ovf = 1'b0;
  endtask

  // Acks on the n-th bus cycle; counts cycles with bus_req high.
  task automatic ack_after(input int n, input logic [31:0] rd, output int cnt);
    cnt = 0;
    for (int i = 0; i < n - 1; i++) begin
      if (bus_req) cnt++;
      cyc();
    end
    bus_ack = 1'b1; bus_rdata = rd;
    if (bus_req) cnt++;
    cyc();
    bus_ack = 1'b0; bus_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_sign = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_ovf = 1'b0;
    flush = 1'b0; bus_rdata = 32'd0; bus_ack = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_req",   32'(bus_req),   32'd0);
    chk("rst_resp",  32'(resp_valid), 32'd0);
    chk("rst_be",    32'(bus_be),    32'd0);
    @(negedge clk); reset = 1'b1;
    cyc();

    // lw 0x10, ack on third bus cycle
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    chk("lw_req",  32'(bus_req), 32'd1);
    chk("lw_be",   32'(bus_be),  32'hF);
    chk("lw_addr", bus_addr,     32'h0000_0010);
    chk("lw_we",   32'(bus_we),  32'd0);
    chk("lw_busy", 32'(req_ready), 32'd0);
    ack_after(3, 32'hDEAD_BEEF, nreq);
    chk("lw_nreq",  32'(nreq),       32'd3);
    chk("lw_valid", 32'(resp_valid), 32'd1);
    chk("lw_rdata", resp_rdata,      32'hDEAD_BEEF);
    chk("lw_exc",   32'(resp_exc),   32'd0);
    cyc();
    chk("lw_idle",  32'(busy),       32'd0);
    chk("lw_vdrop", 32'(resp_valid), 32'd0);

    // lb sign-extended from lane 3
    issue(1'b0, 2'd2, 1'b1, 32'h0000_0013, 32'd0, 1'b0);
    chk("lb_be",   32'(bus_be), 32'b1000);
    chk("lb_addr", bus_addr,    32'h0000_0010);
    ack_after(1, 32'h8012_3456, nreq);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    cyc();

    // lbu same location
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0013, 32'd0, 1'b0);
    ack_after(1, 32'h8012_3456, nreq);
    chk("lbu_rdata", resp_rdata, 32'h0000_0080);
    cyc();

    // lh sign-extended from upper half
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'd0, 1'b0);
    chk("lh_be", 32'(bus_be), 32'b1100);
    ack_after(2, 32'h8012_3456, nreq);
    chk("lh_rdata", resp_rdata, 32'hFFFF_8012);
    cyc();

    // sh 0x22
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 1'b0);
    chk("sh_be",    32'(bus_be), 32'b1100);
    chk("sh_wdata", bus_wdata,   32'hABCD_ABCD);
    chk("sh_we",    32'(bus_we), 32'd1);
    ack_after(1, 32'h1111_1111, nreq);
    chk("sh_valid", 32'(resp_valid), 32'd1);
    chk("sh_exc",   32'(resp_exc),   32'd0);
    chk("sh_rdata", resp_rdata,      32'd0);
    cyc();

    // Timer word read is legal
    issue(1'b0, 2'd0, 1'b0, 32'h0000_7F14, 32'd0, 1'b0);
    chk("tmr_req", 32'(bus_req), 32'd1);
    ack_after(1, 32'h0000_1234, nreq);
    chk("tmr_rdata", resp_rdata, 32'h0000_1234);
    cyc();

    // Faults: no bus cycle, response one cycle after accept
    issue(1'b1, 2'd0, 1'b0, 32'h0000_7F08, 32'h5, 1'b0);
    chk("f1_req",  32'(bus_req),      32'd0);
    chk("f1_val",  32'(resp_valid),   32'd1);
    chk("f1_exc",  32'(resp_exc),     32'd1);
    chk("f1_code", 32'(resp_exccode), 32'd5);
    chk("f1_bad",  resp_badvaddr,     32'h0000_7F08);
    cyc();
    issue(1'b0, 2'd1, 1'b0, 32'h0000_7F00, 32'd0, 1'b0);
    chk("f2_req",  32'(bus_req),      32'd0);
    chk("f2_code", 32'(resp_exccode), 32'd4);
    chk("f2_bad",  resp_badvaddr,     32'h0000_7F00);
    cyc();
    issue(1'b0, 2'd0, 1'b0, 32'h0000_3000, 32'd0, 1'b0);
    chk("f3_req",  32'(bus_req),      32'd0);
    chk("f3_code", 32'(resp_exccode), 32'd4);
    chk("f3_bad",  resp_badvaddr,     32'h0000_3000);
    cyc();
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'd0, 1'b0);
    chk("f4_req",  32'(bus_req),      32'd0);
    chk("f4_exc",  32'(resp_exc),     32'd1);
    chk("f4_code", 32'(resp_exccode), 32'd4);
    chk("f4_bad",  resp_badvaddr,     32'h0000_0002);
    cyc();
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    chk("f5_ovf",  32'(resp_exccode), 32'd4);
    cyc();

    // Timeout: no ack for 16 bus cycles
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'd0, 1'b0);
    nreq = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus_req) nreq++;
      cyc();
    end
    chk("to_nreq",  32'(nreq),         32'd16);
    chk("to_val",   32'(resp_valid),   32'd1);
    chk("to_exc",   32'(resp_exc),     32'd1);
    chk("to_code",  32'(resp_exccode), 32'd4);
    chk("to_rdata", resp_rdata,        32'd0);
    chk("to_bad",   resp_badvaddr,     32'h0000_0004);
    cyc();
    chk("to_idle",  32'(busy), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    cyc();
    bus_ack = 1'b0;
    chk("to_stray_busy", 32'(busy),       32'd0);
    chk("to_stray_val",  32'(resp_valid), 32'd0);

    // Flush one cycle after store accept
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0008, 32'h1122_3344, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_req",   32'(bus_req),  32'd1);
    chk("fl_we",    32'(bus_we),   32'd1);
    chk("fl_wdata", bus_wdata,     32'h1122_3344);
    ack_after(1, 32'd0, nreq);
    chk("fl_kill",  32'(resp_valid), 32'd0);
    chk("fl_busy",  32'(busy),       32'd1);
    cyc();
    chk("fl_ready", 32'(req_ready),  32'd1);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    ack_after(1, 32'h0000_0005, nreq);
    chk("fl_next_val",   32'(resp_valid), 32'd1);
    chk("fl_next_rdata", resp_rdata,      32'h0000_0005);
    cyc();

    // Flush and ack in the same cycle
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    flush = 1'b1;
    ack_after(1, 32'h0000_0077, nreq);
    flush = 1'b0;
    #1;
    chk("fa_kill", 32'(resp_valid), 32'd0);
    chk("fa_busy", 32'(busy),       32'd1);
    cyc();
    chk("fa_idle", 32'(busy), 32'd0);

    // Flush in IDLE drops the request
    flush = 1'b1;
    #1;
    chk("fi_ready", 32'(req_ready), 32'd0);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    flush = 1'b0;
    #1;
    chk("fi_busy", 32'(busy), 32'd0);
    cyc();

    // Reset mid-transfer drops bus_req without a clock edge
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
    chk("mr_req", 32'(bus_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_drop", 32'(bus_req), 32'd0);
    chk("mr_busy", 32'(busy),    32'd0);
    reset = 1'b1;
    cyc();
    chk("mr_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
